// File: rtl/tone_mon_pkg.sv
// Shared types, default limits and helpers for the tone monitor.
package tone_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } chan_state_t;

    // Default limits for a 16-sample tone of amplitude 1000
    localparam int DEF_MIN_PER = 12;
    localparam int DEF_MAX_PER = 20;
    localparam int DEF_MIN_AMP = 750;
    localparam int DEF_MAX_AMP = 1250;

    // Increment that sticks at max_val; callers cast to their own width
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_val);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/tone_mon_chan.sv
// One channel: zero-crossing detector with hysteresis, period/peak
// tracking, limit checks and the IDLE/SETTLE/MEASURE/DONE sequencer.
module tone_mon_chan
    import tone_mon_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 12,
    parameter int ERR_W = 8,
    parameter int HYST  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    start,
    input  logic                    smpl_vld,
    input  logic signed [WIDTH-1:0] smpl,
    input  logic [3:0]              skip_cnt,
    input  logic [CNT_W-1:0]        window,
    input  logic [CNT_W-1:0]        min_per,
    input  logic [CNT_W-1:0]        max_per,
    input  logic signed [WIDTH-1:0] min_amp,
    input  logic signed [WIDTH-1:0] max_amp,
    output chan_state_t             state,
    output logic                    no_cross,
    output logic [ERR_W-1:0]        freq_err,
    output logic [ERR_W-1:0]        ampl_err,
    output logic [CNT_W-1:0]        last_per,
    output logic signed [WIDTH-1:0] last_peak
);

    localparam logic [CNT_W-1:0]        PER_MAX  = '1;
    localparam logic [ERR_W-1:0]        ERR_MAX  = '1;
    localparam logic signed [WIDTH-1:0] NEG_HYST = WIDTH'(-HYST);

    logic                    armed;
    logic [CNT_W-1:0]        per_cnt;
    logic signed [WIDTH-1:0] peak;
    logic [CNT_W-1:0]        win_cnt;
    logic [3:0]              xing_cnt;

    // Run parameters held stable for the whole run
    logic [3:0]              skip_q;
    logic [CNT_W-1:0]        window_q;
    logic [CNT_W-1:0]        min_per_q;
    logic [CNT_W-1:0]        max_per_q;
    logic signed [WIDTH-1:0] min_amp_q;
    logic signed [WIDTH-1:0] max_amp_q;

    logic                    crossing;
    logic                    armed_nxt;
    logic [CNT_W-1:0]        per_nxt;
    logic signed [WIDTH-1:0] peak_nxt;
    logic                    per_bad;
    logic                    amp_bad;
    logic [CNT_W-1:0]        win_next;
    logic [3:0]              xing_next;

    assign win_next  = win_cnt + 1'b1;
    assign xing_next = xing_cnt + 4'd1;

    // Crossing detection, next period/peak values and limit evaluation
    always_comb begin
        crossing  = armed && !smpl[WIDTH-1];
        armed_nxt = armed;
        if (crossing)
            armed_nxt = 1'b0;
        else if (smpl <= NEG_HYST)
            armed_nxt = 1'b1;
        // The crossing sample starts the next period
        per_nxt  = crossing ? CNT_W'(1)
                            : CNT_W'(sat_inc(32'(per_cnt), 32'(PER_MAX)));
        peak_nxt = (crossing || (smpl > peak)) ? smpl : peak;
        // A saturated period counter never counts as in range
        per_bad  = (per_cnt == PER_MAX) || (per_cnt < min_per_q) || (per_cnt > max_per_q);
        amp_bad  = (peak < min_amp_q) || (peak > max_amp_q);
    end

    // Channel sequencer with tracking, checks and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            per_cnt   <= '0;
            peak      <= '0;
            win_cnt   <= '0;
            xing_cnt  <= '0;
            skip_q    <= '0;
            window_q  <= '0;
            min_per_q <= '0;
            max_per_q <= '0;
            min_amp_q <= '0;
            max_amp_q <= '0;
            no_cross  <= 1'b0;
            freq_err  <= '0;
            ampl_err  <= '0;
            last_per  <= '0;
            last_peak <= '0;
        end else if (clr) begin
            state     <= IDLE;
            armed     <= 1'b0;
            per_cnt   <= '0;
            peak      <= '0;
            win_cnt   <= '0;
            xing_cnt  <= '0;
            skip_q    <= '0;
            window_q  <= '0;
            min_per_q <= '0;
            max_per_q <= '0;
            min_amp_q <= '0;
            max_amp_q <= '0;
            no_cross  <= 1'b0;
            freq_err  <= '0;
            ampl_err  <= '0;
            last_per  <= '0;
            last_peak <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        skip_q    <= skip_cnt;
                        window_q  <= window;
                        min_per_q <= min_per;
                        max_per_q <= max_per;
                        min_amp_q <= min_amp;
                        max_amp_q <= max_amp;
                        armed     <= 1'b0;
                        per_cnt   <= '0;
                        peak      <= '0;
                        win_cnt   <= '0;
                        xing_cnt  <= '0;
                        no_cross  <= 1'b0;
                        freq_err  <= '0;
                        ampl_err  <= '0;
                        last_per  <= '0;
                        last_peak <= '0;
                        state     <= (skip_cnt == 4'd0) ? MEASURE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (smpl_vld) begin
                        armed   <= armed_nxt;
                        per_cnt <= per_nxt;
                        peak    <= peak_nxt;
                        if (crossing)
                            xing_cnt <= xing_next;
                        // Reaching the skip count wins over a same-sample timeout
                        if (crossing && (xing_next == skip_q)) begin
                            state   <= MEASURE;
                            win_cnt <= '0;
                        end else if (win_next == window_q) begin
                            state    <= DONE;
                            no_cross <= 1'b1;
                        end else begin
                            win_cnt <= win_next;
                        end
                    end
                end
                MEASURE: begin
                    if (smpl_vld) begin
                        armed   <= armed_nxt;
                        per_cnt <= per_nxt;
                        peak    <= peak_nxt;
                        // Checks use the period that just closed, before the seed
                        if (crossing) begin
                            last_per  <= per_cnt;
                            last_peak <= peak;
                            if (per_bad)
                                freq_err <= ERR_W'(sat_inc(32'(freq_err), 32'(ERR_MAX)));
                            if (amp_bad)
                                ampl_err <= ERR_W'(sat_inc(32'(ampl_err), 32'(ERR_MAX)));
                        end
                        win_cnt <= win_next;
                        if (win_next == window_q)
                            state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tone_monitor.sv
// Multi-channel tone checker: one tone_mon_chan per channel, packed
// result buses, shared busy and an end-of-run done pulse.
module tone_monitor
    import tone_mon_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 12,
    parameter int ERR_W  = 8,
    parameter int HYST   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      smpl_vld,
    input  logic [NUM_CH*WIDTH-1:0]   smpl,
    input  logic                      start,
    input  logic                      clr,
    input  logic [3:0]                skip_cnt,
    input  logic [CNT_W-1:0]          window,
    input  logic [CNT_W-1:0]          min_per,
    input  logic [CNT_W-1:0]          max_per,
    input  logic signed [WIDTH-1:0]   min_amp,
    input  logic signed [WIDTH-1:0]   max_amp,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_CH-1:0]         no_cross,
    output logic [NUM_CH*ERR_W-1:0]   freq_err,
    output logic [NUM_CH*ERR_W-1:0]   ampl_err,
    output logic [NUM_CH*CNT_W-1:0]   last_per,
    output logic [NUM_CH*WIDTH-1:0]   last_peak
);

    chan_state_t       chan_state [NUM_CH];
    logic [NUM_CH-1:0] chan_active;
    logic              start_ok;
    logic              busy_q;

    // A run may only begin when every channel is idle or finished
    assign start_ok = start && !busy;
    assign busy     = |chan_active;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign chan_active[i] = (chan_state[i] == SETTLE) || (chan_state[i] == MEASURE);

        tone_mon_chan #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W),
            .ERR_W (ERR_W),
            .HYST  (HYST)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .start     (start_ok),
            .smpl_vld  (smpl_vld),
            .smpl      ($signed(smpl[i*WIDTH +: WIDTH])),
            .skip_cnt  (skip_cnt),
            .window    (window),
            .min_per   (min_per),
            .max_per   (max_per),
            .min_amp   (min_amp),
            .max_amp   (max_amp),
            .state     (chan_state[i]),
            .no_cross  (no_cross[i]),
            .freq_err  (freq_err[i*ERR_W +: ERR_W]),
            .ampl_err  (ampl_err[i*ERR_W +: ERR_W]),
            .last_per  (last_per[i*CNT_W +: CNT_W]),
            .last_peak (last_peak[i*WIDTH +: WIDTH])
        );
    end

    // done pulses one cycle after busy falls, i.e. after the last channel finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done   <= 1'b0;
        end else if (clr) begin
            busy_q <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy_q <= busy;
            done   <= busy_q && !busy;
        end
    end

endmodule

// File: doc/tone_monitor.md
Name: tone_monitor

Overview:
Synthesizable, parametrised audio-quality checker: the hardware successor to bench-side zero-crossing and peak measurement. Watches NUM_CH signed sample streams, e.g. codec output channels. For each channel it measures the period (samples between negative-to-positive zero crossings) and the per-period peak, checks both against programmable limits, and keeps saturating error counts. Sits beside the codec interface and is read out at DONE by a host or bench.

Parameters:
NUM_CH, 2, number of channels (1..8)
WIDTH, 16, signed sample width
CNT_W, 12, period/window counter width
ERR_W, 8, error counter width
HYST, 16, hysteresis magnitude; a crossing is armed only after a sample <= -HYST

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
smpl_vld  in  1  one-cycle strobe; all channel samples valid this cycle
smpl  in  NUM_CH*WIDTH  packed signed samples; ch0 in LSBs
start  in  1  begin run; ignored while busy
clr  in  1  synchronous abort; returns to IDLE and zeroes results
skip_cnt  in  4  crossings to discard before measuring (settling)
window  in  CNT_W  valid samples measured per channel
min_per, max_per  in  CNT_W each  inclusive period limits
min_amp, max_amp  in  WIDTH each  inclusive signed peak limits
busy  out  1  any channel not IDLE/DONE
done  out  1  one-cycle pulse when the last channel reaches DONE
no_cross  out  NUM_CH  channel timed out in SETTLE
freq_err, ampl_err  out  NUM_CH*ERR_W each  saturating error counts
last_per  out  NUM_CH*CNT_W  most recent measured period
last_peak  out  NUM_CH*WIDTH  most recent measured peak

Behaviour:
- Reset (async) and clr (sync, highest priority): all outputs 0, all channels IDLE, all counters 0.
- Per-channel FSM, state updates only on smpl_vld except start/clr:
  - IDLE -> SETTLE on start. Clears this channel's errors, no_cross, last_per and last_peak; run parameters are latched here.
  - SETTLE -> MEASURE on the skip_cnt-th crossing. skip_cnt=0 enters MEASURE directly on start.
  - MEASURE -> DONE after window valid samples, counted from MEASURE entry.
  - DONE -> SETTLE on the next start.
- Crossing detection:
  - armed <= 1 when sample <= -HYST.
  - Crossing = armed && sample >= 0 (sign bit clear); the crossing clears armed.
  - Noise inside (-HYST, 0) never produces a crossing.
- Per-period tracking:
  - per_cnt increments per valid sample and saturates at all-ones.
  - peak = running signed max.
  - On a crossing, the crossing sample seeds per_cnt=1 and peak=sample.
- Checks at each crossing in MEASURE, using values from before the seed:
  - last_per/last_peak are updated.
  - freq_err++ if per_cnt outside [min_per,max_per]; a saturated per_cnt counts as out of range.
  - ampl_err++ if peak outside [min_amp,max_amp]. Both errors may increment on the same crossing.
  - Error counters saturate at 2^ERR_W-1.
- The SETTLE->MEASURE crossing also seeds, so the first checked period is complete.
- Crossing on the final window sample: the check happens first, then DONE.
- SETTLE timeout: window valid samples without reaching the skip count -> DONE with no_cross=1 and no checks.
- done: single-cycle pulse the cycle after the final channel enters DONE. Channels with different frequencies finish independently.
- Latency: error/last_* registers update one clk after the qualifying smpl_vld.
- start while busy: ignored. start with no smpl_vld: no progress.
- Limits with min > max: every checked period is an error; this is not guarded.

Decomposition:
- Package tone_mon_pkg:
  - chan_state_t enum {IDLE, SETTLE, MEASURE, DONE}.
  - Saturating-increment function.
  - Default limit constants: PER 12..20, AMP 750..1250.
- Sub-module tone_mon_chan holds one channel's FSM, detector, counters and checks.
- tone_monitor:
  - Generates NUM_CH instances.
  - Packs the outputs.
  - Forms busy/done.

Test Plan:
1. 16-sample sine, amplitude 1000, both channels, skip 4, window 2000, limits 12..20/750..1250 -> freq_err=ampl_err=0, last_per=16, last_peak≈1000, one done pulse.
2. Same, ch1 amplitude 2000 -> ch1 ampl_err = crossings in window (125), ch0 = 0.
3. ch0 8-sample sine -> ch0 freq_err=250, last_per=8; ch0 finishes independently of ch1.
4. DC 500 on ch0, window 100 -> ch0 DONE after 100 valid samples, no_cross[0]=1, errors 0.
5. ±10 noise around zero with a HYST=16 build -> no crossings and no_cross set; the same signal offset to ±40 -> crossings detected.
6. Run with ERR_W=4 and all-bad periods -> freq_err sticks at 15. Assert rst_n mid-MEASURE -> all outputs 0 immediately, then a fresh start runs clean. Assert start while busy -> no effect.
